// File: rtl/aes_key_sched_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_sched_iter
// Purpose  : Iterative AES-128 key expansion. Captures a 128-bit key on an
//            accepted start and produces one schedule word per clock
//            (w4..w43) into a registered 1408-bit round-key schedule.
// Ports    : CLK         - system clock, rising edge
//            RESET       - synchronous active-high reset
//            KS_START    - start request (sampled in IDLE/DONE only)
//            KS_KEY      - 128-bit cipher key, captured on accepted start
//            KS_BUSY     - expansion in progress
//            KS_READY    - schedule complete for last accepted key
//            KS_SCHEDULE - round key i at [128*i +: 128], w[4i] in MSBs
// Options  : AES_KEYSCHED_CACHE_EN - when defined, a restart with the key of
//            the last completed expansion skips EXPAND entirely.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_sched_iter (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          KS_START,
  input  logic [127:0]  KS_KEY,
  output logic          KS_BUSY,
  output logic          KS_READY,
  output logic [1407:0] KS_SCHEDULE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Forward S-box, entry 0x00 in the MSB byte. Entry b therefore lives at
  // bit range [(255-b)*8+7 -: 8], i.e. index {~b, 3'b111}.
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Bit offset of word k inside the schedule: round key k/4, with word
  // k%4 == 0 at the top of that 128-bit slot.
  function automatic logic [10:0] word_base(input logic [5:0] k);
    word_base = {k[5:2], 7'b0} + {4'b0, 2'(2'd3 - k[1:0]), 5'b0};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [5:0]      wi_q, wi_d;
  logic [1407:0]   sched_q, sched_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;

  // Word counter used for operand addressing. Outside EXPAND it is pinned
  // to a legal value so the variable part-selects never leave the schedule.
  logic [5:0]      wi_rd;
  logic [10:0]     base_prev, base_old, base_wr;
  logic [31:0]     w_prev, w_old, w_rot, w_sub, w_temp, w_new;
  logic            cache_hit;

  assign wi_rd     = (state_q == ST_EXPAND) ? wi_q : 6'd4;
  assign base_prev = word_base(6'(wi_rd - 6'd1));
  assign base_old  = word_base(6'(wi_rd - 6'd4));
  assign base_wr   = word_base(wi_rd);

  // Operands come straight out of the schedule register.
  assign w_prev = sched_q[base_prev +: 32];
  assign w_old  = sched_q[base_old  +: 32];
  assign w_rot  = {w_prev[23:0], w_prev[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sbox
      assign w_sub[8*g +: 8] = C_SBOX[{~w_rot[8*g +: 8], 3'b111} -: 8];
    end
  endgenerate

  assign w_temp = (wi_rd[1:0] == 2'd0) ? (w_sub ^ {rcon(wi_rd[5:2]), 24'h0}) : w_prev;
  assign w_new  = w_old ^ w_temp;

`ifdef AES_KEYSCHED_CACHE_EN
  logic [127:0] cache_key_q;
  logic         cache_vld_q;

  // The cache is loaded from slot 0 as the final word is written, so it
  // always names the key whose schedule is about to be complete.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cache_key_q <= 128'h0;
      cache_vld_q <= 1'b0;
    end else if (state_q == ST_EXPAND && wi_q == 6'd43) begin
      cache_key_q <= sched_q[127:0];
      cache_vld_q <= 1'b1;
    end
  end

  assign cache_hit = cache_vld_q && (KS_KEY == cache_key_q);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    sched_d = sched_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (KS_START) begin
          if (cache_hit) begin
            // Schedule already matches this key; stay ready.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            sched_d[127:0] = KS_KEY;
            wi_d           = 6'd4;
            busy_d         = 1'b1;
            ready_d        = 1'b0;
            state_d        = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        sched_d[base_wr +: 32] = w_new;
        wi_d = 6'(wi_q + 6'd1);
        if (wi_q == 6'd43) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      wi_q    <= 6'd0;
      sched_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      sched_q <= sched_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign KS_BUSY     = busy_q;
  assign KS_READY    = ready_q;
  assign KS_SCHEDULE = sched_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_sched_iter
// Purpose  : Self-checking bench for aes_key_sched_iter. Stimulus pushes the
//            expected schedule of each expansion into a queue; a monitor pops
//            and compares whenever KS_READY rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_iter;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          KS_START;
  logic [127:0]  KS_KEY;
  logic          KS_BUSY;
  logic          KS_READY;
  logic [1407:0] KS_SCHEDULE;

  aes_key_sched_iter dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .KS_START    (KS_START),
    .KS_KEY      (KS_KEY),
    .KS_BUSY     (KS_BUSY),
    .KS_READY    (KS_READY),
    .KS_SCHEDULE (KS_SCHEDULE)
  );

  always #5 CLK = ~CLK;

  localparam logic [127:0] C_FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] C_FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_ZERO_KEY  = 128'h0;
  localparam logic [127:0] C_ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] C_ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] rk0;
    logic [127:0] rk1;
    logic [127:0] rk10;
    int           e0;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every rising KS_READY must correspond to a queued expansion.
  logic ready_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (KS_READY && !ready_prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: ready rose at cycle %0d with nothing queued", cyc);
      end else begin
        e = sb_q.pop_front();
        check("rk0",     KS_SCHEDULE[0    +: 128], e.rk0);
        check("rk1",     KS_SCHEDULE[128  +: 128], e.rk1);
        check("rk10",    KS_SCHEDULE[1280 +: 128], e.rk10);
        check("latency", 128'(cyc - e.e0), 128'd40);
        check("busy_at_ready", 128'(KS_BUSY), 128'd0);
      end
    end
    ready_prev = KS_READY;
  end

  task automatic start_key(input logic [127:0] k, input bit expect_done,
                           input logic [127:0] r1, input logic [127:0] r10);
    exp_t e;
    @(negedge CLK);
    KS_KEY   = k;
    KS_START = 1'b1;
    @(posedge CLK);
    #1;
    KS_START = 1'b0;
    if (expect_done) begin
      e.rk0  = k;
      e.rk1  = r1;
      e.rk10 = r10;
      e.e0   = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!KS_READY && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (!KS_READY) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: ready timeout, got 0, required 1", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET    = 1'b1;
    KS_START = 1'b0;
    KS_KEY   = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy",  128'(KS_BUSY), 128'd0);
    check("reset_ready", 128'(KS_READY), 128'd0);
    check("reset_sched", 128'(|KS_SCHEDULE), 128'd0);
    RESET = 1'b0;

    // FIPS-197 key, with a probe one edge before completion.
    start_key(C_FIPS_KEY, 1'b1, C_FIPS_RK1, C_FIPS_RK10);
    repeat (40) @(negedge CLK);
    check("fips_busy_e39",  128'(KS_BUSY), 128'd1);
    check("fips_ready_e39", 128'(KS_READY), 128'd0);
    wait_ready("fips");

    // Back-to-back from DONE: zero key, then FIPS key.
    start_key(C_ZERO_KEY, 1'b1, C_ZERO_RK1, C_ZERO_RK10);
    @(negedge CLK);
    check("b2b_zero_ready_drop", 128'(KS_READY), 128'd0);
    wait_ready("b2b_zero");
    start_key(C_FIPS_KEY, 1'b1, C_FIPS_RK1, C_FIPS_RK10);
    @(negedge CLK);
    check("b2b_fips_ready_drop", 128'(KS_READY), 128'd0);
    wait_ready("b2b_fips");

    // Start and key change at E0+10 must be ignored.
    start_key(C_ZERO_KEY, 1'b1, C_ZERO_RK1, C_ZERO_RK10);
    wait_ready("pre_mid");
    start_key(C_FIPS_KEY, 1'b1, C_FIPS_RK1, C_FIPS_RK10);
    repeat (10) @(negedge CLK);
    KS_KEY   = C_ZERO_KEY;
    KS_START = 1'b1;
    @(posedge CLK);
    #1;
    KS_START = 1'b0;
    repeat (30) @(negedge CLK);
    check("mid_busy_e39", 128'(KS_BUSY), 128'd1);
    wait_ready("mid_change");

    // Reset at E0+20 aborts the expansion.
    start_key(C_ZERO_KEY, 1'b0, '0, '0);
    repeat (20) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("rst_mid_busy",  128'(KS_BUSY), 128'd0);
    check("rst_mid_ready", 128'(KS_READY), 128'd0);
    check("rst_mid_sched", 128'(|KS_SCHEDULE), 128'd0);
    repeat (3) @(negedge CLK);
    check("rst_mid_idle_busy", 128'(KS_BUSY), 128'd0);
    start_key(C_FIPS_KEY, 1'b1, C_FIPS_RK1, C_FIPS_RK10);
    wait_ready("after_reset");

`ifdef AES_KEYSCHED_CACHE_EN
    // Same key again: ready stays high, busy never asserts.
    start_key(C_FIPS_KEY, 1'b0, '0, '0);
    @(negedge CLK);
    check("cache_ready", 128'(KS_READY), 128'd1);
    check("cache_busy",  128'(KS_BUSY), 128'd0);
    repeat (5) @(negedge CLK);
    check("cache_busy_later", 128'(KS_BUSY), 128'd0);
    check("cache_rk10", KS_SCHEDULE[1280 +: 128], C_FIPS_RK10);
    start_key(C_ZERO_KEY, 1'b1, C_ZERO_RK1, C_ZERO_RK10);
    @(negedge CLK);
    check("cache_miss_ready_drop", 128'(KS_READY), 128'd0);
    wait_ready("cache_miss");
`endif

    repeat (3) @(negedge CLK);
    check("queue_drained", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
